// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared definitions for the ALU sequencer slice.
//   - op_code encodings (OP_ADC .. OP_DEC); 12-15 are illegal
//   - sequencer state encoding (S_IDLE, S_PASS1, S_PASS2, S_DONE)
//   - small decode helpers used by the sequencer
package alu_sequencer_pkg;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_EOR = 4'd3;
    localparam logic [3:0] OP_ORA = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_DEC;
    endfunction

    // Ops that may need a second "+k" pass because the ALU has no carry-in.
    function automatic logic op_has_pass2(input logic [3:0] op);
        return (op == OP_ADC) || (op == OP_SBC) || (op == OP_CMP) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundles the core-side op/result handshake and the ALU_block
// select/operand bus seen by the sequencer.
//   master : execution core + ALU side (drives op_*, res_ready, alu_out, alu_acr)
//   slave  : the sequencer (drives op_ready, res_*, alu select lines/operands)
interface alu_sequencer_if;

    // operation request
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic [7:0] op_a;
    logic [7:0] op_m;
    logic       flag_c_in;

    // result return
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_n;
    logic       res_z;
    logic       res_c;
    logic       res_v;
    logic       res_err;

    // ALU_block control and data
    logic       alu_sums;
    logic       alu_ands;
    logic       alu_eors;
    logic       alu_ors;
    logic       alu_srs;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_carry_in;
    logic [7:0] alu_out;
    logic       alu_acr;

    modport master (
        output op_valid, op_code, op_a, op_m, flag_c_in, res_ready, alu_out, alu_acr,
        input  op_ready, res_valid, res_data, res_n, res_z, res_c, res_v, res_err,
        input  alu_sums, alu_ands, alu_eors, alu_ors, alu_srs, alu_a, alu_b, alu_carry_in
    );

    modport slave (
        input  op_valid, op_code, op_a, op_m, flag_c_in, res_ready, alu_out, alu_acr,
        output op_ready, res_valid, res_data, res_n, res_z, res_c, res_v, res_err,
        output alu_sums, alu_ands, alu_eors, alu_ors, alu_srs, alu_a, alu_b, alu_carry_in
    );

endinterface

// File: rtl/alu_sequencer_flag_calc.sv
// alu_sequencer_flag_calc: combinational final result and N/Z/C/V for one op.
// Inputs : op, a (latched A), m_msb (bit 7 of latched M), c_in (latched C),
//          r1/c1 (PASS1 capture), r2/c2 (PASS2 capture, or r1/0 if no PASS2)
// Outputs: data, n, z, c, v, err
module alu_sequencer_flag_calc
    import alu_sequencer_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic       m_msb,
    input  logic       c_in,
    input  logic [7:0] r1,
    input  logic       c1,
    input  logic [7:0] r2,
    input  logic       c2,
    output logic [7:0] data,
    output logic       n,
    output logic       z,
    output logic       c,
    output logic       v,
    output logic       err
);

    logic [7:0] result;
    logic       b_msb;

    always_comb begin
        result = r1;
        c      = c_in;
        err    = 1'b0;
        unique case (op)
            OP_ADC, OP_SBC, OP_CMP, OP_ROL: begin
                // The two passes can never both carry, so OR is the true carry out.
                result = r2;
                c      = c1 | c2;
            end
            OP_ASL, OP_LSR: c = c1;
            OP_ROR: begin
                result = {c_in, r1[6:0]};
                c      = c1;
            end
            OP_AND, OP_EOR, OP_ORA, OP_INC, OP_DEC: c = c_in;
            default: err = 1'b1;
        endcase

        // ALU AVR is wrong across two passes; derive V from operand/result signs.
        b_msb = (op == OP_SBC) ? ~m_msb : m_msb;
        v     = ((op == OP_ADC) || (op == OP_SBC)) &&
                (a[7] == b_msb) && (result[7] != a[7]);

        data = ((op == OP_CMP) || err) ? a : result;
        n    = !err && result[7];
        z    = !err && (result == 8'h00);
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller in front of the combinational ALU_block.
// Accepts one 6502 ALU op per handshake, runs one or two ALU passes (carry-in,
// subtract, compare, rotate and inc/dec are synthesised from plain adds), then
// holds result + N/Z/C/V until the core takes it.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_sequencer_if.slave: op request, result return, ALU select/operand bus
// Parameter:
//   SKIP_ZERO_CARRY - 1: omit the "+k" pass when k is 0; 0: always run it
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter bit SKIP_ZERO_CARRY = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);

    state_e     state_q, state_d;

    logic [3:0] op_q;
    logic [7:0] a_q;
    logic [7:0] m_q;
    logic       cin_q;
    logic [7:0] r1_q;
    logic       c1_q;
    logic [7:0] r2_q;
    logic       c2_q;

    logic       pass2_k;
    logic       take_pass2;

    logic [7:0] calc_data;
    logic       calc_n;
    logic       calc_z;
    logic       calc_c;
    logic       calc_v;
    logic       calc_err;

    // CMP always adds the +1 that completes A + ~M + 1; others add the latched carry.
    assign pass2_k    = (op_q == OP_CMP) ? 1'b1 : cin_q;
    assign take_pass2 = op_has_pass2(op_q) && (pass2_k || !SKIP_ZERO_CARRY);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    state_d = op_is_legal(bus.op_code) ? S_PASS1 : S_DONE;
                end
            end
            S_PASS1: state_d = take_pass2 ? S_PASS2 : S_DONE;
            S_PASS2: state_d = S_DONE;
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- operand / pass capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= 4'h0;
            a_q   <= 8'h00;
            m_q   <= 8'h00;
            cin_q <= 1'b0;
            r1_q  <= 8'h00;
            c1_q  <= 1'b0;
            r2_q  <= 8'h00;
            c2_q  <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && bus.op_valid) begin
                op_q  <= bus.op_code;
                a_q   <= bus.op_a;
                m_q   <= bus.op_m;
                cin_q <= bus.flag_c_in;
            end
            if (state_q == S_PASS1) begin
                r1_q <= bus.alu_out;
                c1_q <= bus.alu_acr;
                // Preset the PASS2 capture so a skipped pass leaves r2=r1, c2=0.
                r2_q <= bus.alu_out;
                c2_q <= 1'b0;
            end
            if (state_q == S_PASS2) begin
                r2_q <= bus.alu_out;
                c2_q <= bus.alu_acr;
            end
        end
    end

    // ---------------------------------------------------------------- flag calculation
    alu_sequencer_flag_calc u_flag_calc (
        .op    (op_q),
        .a     (a_q),
        .m_msb (m_q[7]),
        .c_in  (cin_q),
        .r1    (r1_q),
        .c1    (c1_q),
        .r2    (r2_q),
        .c2    (c2_q),
        .data  (calc_data),
        .n     (calc_n),
        .z     (calc_z),
        .c     (calc_c),
        .v     (calc_v),
        .err   (calc_err)
    );

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.op_ready     = (state_q == S_IDLE);
        bus.res_valid    = (state_q == S_DONE);
        bus.res_data     = 8'h00;
        bus.res_n        = 1'b0;
        bus.res_z        = 1'b0;
        bus.res_c        = 1'b0;
        bus.res_v        = 1'b0;
        bus.res_err      = 1'b0;
        bus.alu_sums     = 1'b0;
        bus.alu_ands     = 1'b0;
        bus.alu_eors     = 1'b0;
        bus.alu_ors      = 1'b0;
        bus.alu_srs      = 1'b0;
        bus.alu_a        = 8'h00;
        bus.alu_b        = 8'h00;
        bus.alu_carry_in = 1'b0;

        unique case (state_q)
            S_PASS1: begin
                bus.alu_a = a_q;
                unique case (op_q)
                    OP_ADC: begin
                        bus.alu_sums = 1'b1;
                        bus.alu_b    = m_q;
                    end
                    OP_SBC, OP_CMP: begin
                        bus.alu_sums = 1'b1;
                        bus.alu_b    = ~m_q;
                    end
                    OP_AND: begin
                        bus.alu_ands = 1'b1;
                        bus.alu_b    = m_q;
                    end
                    OP_EOR: begin
                        bus.alu_eors = 1'b1;
                        bus.alu_b    = m_q;
                    end
                    OP_ORA: begin
                        bus.alu_ors = 1'b1;
                        bus.alu_b   = m_q;
                    end
                    OP_ASL, OP_ROL: begin
                        bus.alu_sums = 1'b1;
                        bus.alu_b    = a_q;
                    end
                    OP_LSR, OP_ROR: bus.alu_srs = 1'b1;
                    OP_INC: begin
                        bus.alu_sums = 1'b1;
                        bus.alu_b    = 8'h01;
                    end
                    OP_DEC: begin
                        bus.alu_sums = 1'b1;
                        bus.alu_b    = 8'hFF;
                    end
                    // Illegal ops never reach PASS1; keep the bus quiet regardless.
                    default: bus.alu_a = 8'h00;
                endcase
            end
            S_PASS2: begin
                bus.alu_sums = 1'b1;
                bus.alu_a    = r1_q;
                bus.alu_b    = {7'b0, pass2_k};
            end
            S_DONE: begin
                bus.res_data = calc_data;
                bus.res_n    = calc_n;
                bus.res_z    = calc_z;
                bus.res_c    = calc_c;
                bus.res_v    = calc_v;
                bus.res_err  = calc_err;
            end
            default: bus.op_ready = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench. Two sequencers (SKIP_ZERO_CARRY
// 0 and 1) each sit in front of a behavioural ALU_block model; hand-computed
// vectors are pushed through and result, flags and latency are compared.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] op_code   = 4'h0;
    logic [7:0] op_a      = 8'h00;
    logic [7:0] op_m      = 8'h00;
    logic       flag_c_in = 1'b0;
    logic [1:0] op_valid  = 2'b00;
    logic [1:0] res_ready = 2'b00;

    int n_compared   = 0;
    int n_mismatched = 0;

    alu_sequencer_if bus0 ();
    alu_sequencer_if bus1 ();

    assign bus0.op_code   = op_code;
    assign bus0.op_a      = op_a;
    assign bus0.op_m      = op_m;
    assign bus0.flag_c_in = flag_c_in;
    assign bus0.op_valid  = op_valid[0];
    assign bus0.res_ready = res_ready[0];
    assign bus1.op_code   = op_code;
    assign bus1.op_a      = op_a;
    assign bus1.op_m      = op_m;
    assign bus1.flag_c_in = flag_c_in;
    assign bus1.op_valid  = op_valid[1];
    assign bus1.res_ready = res_ready[1];

    alu_sequencer #(.SKIP_ZERO_CARRY(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    alu_sequencer #(.SKIP_ZERO_CARRY(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Behavioural ALU_block: {acr, out}. Idle bus returns junk so any sampling
    // outside a pass corrupts the result.
    function automatic logic [8:0] alu_model(input logic [4:0] sel, input logic [7:0] a,
                                             input logic [7:0] b);
        case (sel)
            5'b10000: return {1'b0, a} + {1'b0, b};
            5'b01000: return {1'b0, a & b};
            5'b00100: return {1'b0, a ^ b};
            5'b00010: return {1'b0, a | b};
            5'b00001: return {a[0], 1'b0, a[7:1]};
            default:  return 9'h15A;
        endcase
    endfunction

    always_comb begin
        {bus0.alu_acr, bus0.alu_out} = alu_model({bus0.alu_sums, bus0.alu_ands, bus0.alu_eors,
                                                  bus0.alu_ors, bus0.alu_srs},
                                                 bus0.alu_a, bus0.alu_b);
        {bus1.alu_acr, bus1.alu_out} = alu_model({bus1.alu_sums, bus1.alu_ands, bus1.alu_eors,
                                                  bus1.alu_ors, bus1.alu_srs},
                                                 bus1.alu_a, bus1.alu_b);
    end

    // {op_ready, res_valid, res_data[7:0], n, z, c, v, err}
    function automatic logic [14:0] status(input bit sel);
        if (sel) begin
            return {bus1.op_ready, bus1.res_valid, bus1.res_data, bus1.res_n, bus1.res_z,
                    bus1.res_c, bus1.res_v, bus1.res_err};
        end
        return {bus0.op_ready, bus0.res_valid, bus0.res_data, bus0.res_n, bus0.res_z,
                bus0.res_c, bus0.res_v, bus0.res_err};
    endfunction

    // {sums, ands, eors, ors, srs, carry_in, alu_a, alu_b} of dut1
    function automatic logic [21:0] alu_bus1();
        return {bus1.alu_sums, bus1.alu_ands, bus1.alu_eors, bus1.alu_ors, bus1.alu_srs,
                bus1.alu_carry_in, bus1.alu_a, bus1.alu_b};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, measure latency, check, retire.
    // exp_flags = {n, z, c, v, err}
    task automatic run_op(input bit sel, input string tag, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] m, input logic cin,
                          input logic [7:0] exp_data, input logic [4:0] exp_flags,
                          input int exp_lat);
        logic [14:0] st;
        int          lat;
        @(negedge clk);
        op_code       = op;
        op_a          = a;
        op_m          = m;
        flag_c_in     = cin;
        op_valid[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid[sel] = 1'b0;
        op_code       = OP_AND;
        op_a          = ~a;
        op_m          = ~m;
        flag_c_in     = ~cin;
        lat = 1;
        st  = status(sel);
        while (!st[13] && lat < 8) begin
            @(negedge clk);
            lat++;
            st = status(sel);
        end
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " data"}, st[12:5], exp_data);
        check_eq({tag, " flags"}, st[4:0], exp_flags);
        res_ready[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready[sel] = 1'b0;
        st = status(sel);
        check_eq({tag, " back to idle"}, st[14:13], 2'b10);
    endtask

    initial begin
        logic [14:0] st;
        int          lat;
        bit          seen;

        #2;
        check_eq("reset status dut1", status(1'b1), 15'h4000);
        check_eq("reset status dut0", status(1'b0), 15'h4000);
        check_eq("reset alu bus", alu_bus1(), 22'h0);
        @(negedge clk);
        rst = 1'b0;

        //     sel  tag          op      A      M      C     data   {nzcve}  lat
        run_op(1, "adc skip",   OP_ADC, 8'h50, 8'h50, 1'b0, 8'hA0, 5'b10010, 2);
        run_op(0, "adc noskip", OP_ADC, 8'h50, 8'h50, 1'b0, 8'hA0, 5'b10010, 3);
        run_op(1, "sbc 00-01",  OP_SBC, 8'h00, 8'h01, 1'b1, 8'hFF, 5'b10000, 3);
        run_op(1, "sbc 80-01",  OP_SBC, 8'h80, 8'h01, 1'b1, 8'h7F, 5'b00110, 3);
        run_op(1, "cmp eq",     OP_CMP, 8'h42, 8'h42, 1'b0, 8'h42, 5'b01100, 3);
        run_op(1, "cmp lt",     OP_CMP, 8'h10, 8'h20, 1'b1, 8'h10, 5'b10000, 3);
        run_op(1, "rol 80",     OP_ROL, 8'h80, 8'h00, 1'b1, 8'h01, 5'b00100, 3);
        run_op(1, "rol 40 skip", OP_ROL, 8'h40, 8'h00, 1'b0, 8'h80, 5'b10000, 2);
        run_op(0, "rol 40 noskip", OP_ROL, 8'h40, 8'h00, 1'b0, 8'h80, 5'b10000, 3);
        run_op(1, "ror 01",     OP_ROR, 8'h01, 8'h00, 1'b1, 8'h80, 5'b10100, 2);
        run_op(1, "lsr 01",     OP_LSR, 8'h01, 8'h00, 1'b0, 8'h00, 5'b01100, 2);
        run_op(1, "asl 81",     OP_ASL, 8'h81, 8'h00, 1'b0, 8'h02, 5'b00100, 2);
        run_op(1, "and",        OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 5'b00100, 2);
        run_op(1, "eor",        OP_EOR, 8'hFF, 8'h0F, 1'b0, 8'hF0, 5'b10000, 2);
        run_op(1, "ora zero",   OP_ORA, 8'h00, 8'h00, 1'b0, 8'h00, 5'b01000, 2);
        run_op(1, "inc ff",     OP_INC, 8'hFF, 8'h00, 1'b0, 8'h00, 5'b01000, 2);
        run_op(1, "dec 00",     OP_DEC, 8'h00, 8'h00, 1'b1, 8'hFF, 5'b10100, 2);
        run_op(1, "adc ff+01+c", OP_ADC, 8'hFF, 8'h01, 1'b1, 8'h01, 5'b00100, 3);
        run_op(1, "illegal 13", 4'd13,  8'h77, 8'h12, 1'b1, 8'h77, 5'b00101, 1);

        // Back-pressure: result held while a new request waits with op_valid high.
        @(negedge clk);
        op_code     = OP_ADC;
        op_a        = 8'h01;
        op_m        = 8'h02;
        flag_c_in   = 1'b0;
        op_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_code = OP_INC;
        op_a    = 8'h10;
        op_m    = 8'h00;
        lat = 1;
        st  = status(1'b1);
        while (!st[13] && lat < 8) begin
            @(negedge clk);
            lat++;
            st = status(1'b1);
        end
        check_eq("stall latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall hold", status(1'b1), {1'b0, 1'b1, 8'h03, 5'b00000});
            @(negedge clk);
        end
        res_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready[1] = 1'b0;
        st = status(1'b1);
        check_eq("stall release idle", st[14:13], 2'b10);
        @(posedge clk);
        @(negedge clk);
        op_valid[1] = 1'b0;
        lat = 1;
        st  = status(1'b1);
        while (!st[13] && lat < 8) begin
            @(negedge clk);
            lat++;
            st = status(1'b1);
        end
        check_eq("post-stall latency", lat, 2);
        check_eq("post-stall data", st[12:5], 8'h11);
        check_eq("post-stall flags", st[4:0], 5'b00000);
        res_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready[1] = 1'b0;

        // Reset during PASS2 of an ADC.
        op_code     = OP_ADC;
        op_a        = 8'h10;
        op_m        = 8'h20;
        flag_c_in   = 1'b1;
        op_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid[1] = 1'b0;
        check_eq("pass1 alu bus", alu_bus1(), {6'b100000, 8'h10, 8'h20});
        @(negedge clk);
        check_eq("pass2 alu bus", alu_bus1(), {6'b100000, 8'h30, 8'h01});
        rst = 1'b1;
        #1;
        check_eq("mid-op reset status", status(1'b1), 15'h4000);
        check_eq("mid-op reset alu bus", alu_bus1(), 22'h0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            st = status(1'b1);
            if (st[13]) seen = 1'b1;
        end
        check_eq("no result after reset", seen, 1'b0);
        run_op(1, "after reset", OP_ADC, 8'h10, 8'h20, 1'b1, 8'h31, 5'b00000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller in front of the combinational ALU_block. Accepts one 6502 ALU operation per handshake and drives the ALU select lines and operands. ALU_block has no working carry-in and no subtract, so carry-in, subtract, compare, rotate and inc/dec are built from one or two ALU passes. Computes final N/Z/C/V and returns result plus flags to the execution core.

Parameters:
SKIP_ZERO_CARRY, 1, when 1 the second (+carry) pass is omitted when its addend is 0; when 0 two-pass ops always take two passes.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
op_valid  in  1  operation request
op_ready  out  1  sequencer can accept (high only in IDLE)
op_code  in  4  0 ADC, 1 SBC, 2 AND, 3 EOR, 4 ORA, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 CMP, 10 INC, 11 DEC, 12-15 illegal
op_a  in  8  accumulator/register operand
op_m  in  8  memory operand
flag_c_in  in  1  current C flag
res_valid  out  1  result available
res_ready  in  1  core consumes result
res_data  out  8  result byte
res_n, res_z, res_c, res_v  out  1 each  resulting flags
res_err  out  1  illegal op_code
alu_sums, alu_ands, alu_eors, alu_ors, alu_srs  out  1 each  ALU select lines, one-hot or all zero
alu_a, alu_b  out  8 each  ALU operands
alu_carry_in  out  1  tied 0
alu_out  in  8  ALU result
alu_acr  in  1  ALU carry (sampled only in an active pass)

Behaviour:
- Reset (async): state IDLE, op_ready=1, res_valid=0, all res_* = 0, all alu_* outputs = 0, latched operands cleared.
- States: IDLE -> PASS1 -> (PASS2) -> DONE -> IDLE.
- IDLE: op_ready=1. On op_valid&op_ready, latch op_code, op_a, op_m and flag_c_in, then go to PASS1. Illegal op_code goes straight to DONE with res_data=op_a, res_err=1, flags equal to the prior C and other flags 0.
- PASS1 (one cycle): drive exactly one select line. Capture alu_out and alu_acr at the end of the cycle into r1 and c1.
  - ADC: SUMS with A and M.
  - SBC, CMP: SUMS with A and ~M.
  - AND/EOR/ORA: the matching select with A and M.
  - ASL, ROL: SUMS with A and A.
  - LSR, ROR: SRS with A.
  - INC: SUMS with A and 8'h01.
  - DEC: SUMS with A and 8'hFF.
- PASS2 (ADC, SBC, CMP, ROL only): addend k is C-in for ADC, SBC and ROL, and 1 for CMP. Drive SUMS with r1 and {7'b0,k}. Capture r2 and c2. Final C = c1|c2.
  - If SKIP_ZERO_CARRY=1 and k=0, skip PASS2: r2=r1, C=c1.
- ROR takes no second ALU pass: result = {C-in, r1[6:0]}, C = bit 0 of op_a (alu_acr from PASS1).
- Flags:
  - N = result[7]; Z = (result==0). For CMP, N and Z come from the subtraction but res_data = op_a.
  - C: arithmetic and shift ops as above. INC/DEC/AND/EOR/ORA keep the latched C-in.
  - V: ADC/SBC only, V = (a7==b7)&&(res7!=a7), where b = M for ADC and ~M for SBC. The sequencer computes V itself because ALU AVR is wrong across two passes. All other ops keep V=0.
- DONE: res_valid=1 and all res_* outputs are held stable until res_ready. Transfer happens on res_valid&res_ready; go to IDLE on the same edge. op_ready is 0 in DONE (no overlap).
- ALU select lines and operands are 0 outside PASS1/PASS2. The ALU floats its outputs when no select is active, so alu_out and alu_acr are never sampled outside a pass.
- Latency from accept to res_valid: 2 cycles for single-pass ops, 3 for two-pass. Best throughput is 1 op per 3 cycles.
- op_valid held while not ready is ignored. Operands change only at accept.
- Reset mid-operation aborts immediately. No partial result is emitted.
- Decimal mode is not supported. The D flag is not an input, and ADC/SBC are binary only.

Decomposition:
- Shared package (alu_pkg): op_code localparams (OP_ADC..OP_DEC) and state encodings (S_IDLE, S_PASS1, S_PASS2, S_DONE).
- One natural sub-module: alu_flag_calc, combinational N/Z/V/C from op, operands, result and carries.
- The sequencer instantiates alu_flag_calc; ALU_block is instantiated alongside it at the core level.

Test Plan:
- ADC A=0x50, M=0x50, C=0 -> res 0xA0, N=1, Z=0, C=0, V=1. res_valid 2 cycles after accept with SKIP_ZERO_CARRY=1, 3 cycles with 0.
- SBC A=0x00, M=0x01, C=1 -> two passes, res 0xFF, N=1, C=0, V=0. SBC A=0x80, M=0x01, C=1 -> res 0x7F, C=1, V=1.
- CMP A=0x42, M=0x42 -> res_data 0x42, Z=1, C=1, N=0. CMP A=0x10, M=0x20 -> Z=0, C=0, N=1.
- ROL A=0x80, C=1 -> res 0x01, C=1, Z=0. ROR A=0x01, C=1 -> res 0x80, C=1, N=1. LSR A=0x01 -> res 0x00, Z=1, C=1.
- Hold res_ready=0 for 5 cycles after res_valid: outputs stable, op_ready=0, new op_valid ignored. Release: IDLE next cycle, next op accepted.
- Assert rst during PASS2 of an ADC: async clear, res_valid never asserts. op_code 13 -> res_err=1, res_data=op_a, latency 1 cycle.
